lfsr_rng: RTL and testbench

//  Parametrised Fibonacci LFSR with runtime reseed, multi-bit advance, and a bounded-draw engine.

---
 rtl/lfsr_rng_if.sv | 28 ++
 rtl/lfsr_rng.sv | 146 ++++++++++++++
 tb/tb_lfsr_rng.sv | 371 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lfsr_rng_if.sv
// Request/response and control bundle for lfsr_rng.
// The master side drives seeding, advance and draw requests.
// The slave side (the generator) returns raw state and bounded draws.
interface lfsr_rng_if #(
  parameter int WIDTH = 16
);
  logic             next_i;
  logic             seed_valid_i;
  logic [WIDTH-1:0] seed_i;
  logic [WIDTH-1:0] rand_o;
  logic             req_valid_i;
  logic             req_ready_o;
  logic [WIDTH-1:0] range_i;
  logic             rsp_valid_o;
  logic             rsp_ready_i;
  logic [WIDTH-1:0] rsp_o;
  logic             rsp_fallback_o;

  modport master (
    output next_i, seed_valid_i, seed_i, req_valid_i, range_i, rsp_ready_i,
    input  rand_o, req_ready_o, rsp_valid_o, rsp_o, rsp_fallback_o
  );

  modport slave (
    input  next_i, seed_valid_i, seed_i, req_valid_i, range_i, rsp_ready_i,
    output rand_o, req_ready_o, rsp_valid_o, rsp_o, rsp_fallback_o
  );
endinterface

// File: rtl/lfsr_rng.sv
// Fibonacci LFSR random source with runtime reseed, STEP-shift advance,
// and a bounded-draw engine returning values in [0, range).
// Draws use masked rejection sampling. If every attempt is rejected, the
// last candidate is folded back into range by one subtraction. This works
// because the mask is less than twice the range.
module lfsr_rng #(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] TAPS     = WIDTH'(16'hB400),
  parameter logic [WIDTH-1:0] SEED     = WIDTH'(1),
  parameter int              STEP      = 1,
  parameter int              MAX_TRIES = 8
) (
  input logic        clk_i,
  input logic        rst_i,
  lfsr_rng_if.slave  bus
);

  localparam int TW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
  localparam logic [TW-1:0] LAST_TRY = TW'(MAX_TRIES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    RESP = 2'd2
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [WIDTH-1:0] lfsr_q, lfsr_d;
  logic [WIDTH-1:0] range_q, range_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [TW-1:0]    tries_q, tries_d;
  logic [WIDTH-1:0] rsp_q, rsp_d;
  logic             fallback_q, fallback_d;
  logic [WIDTH-1:0] adv_state;
  logic [WIDTH-1:0] cand;
  logic             do_advance;

  // One Fibonacci shift: feedback is the parity of the tapped bits.
  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], ^(s & TAPS)};
  endfunction

  // STEP chained shifts, unrolled into a single combinational advance.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] r;
    r = s;
    for (int i = 0; i < STEP; i++) begin
      r = shift_once(r);
    end
    return r;
  endfunction

  // Smallest all-ones mask covering range-1; range 0 wraps to all ones and range 1 gives 0.
  function automatic logic [WIDTH-1:0] range_mask(input logic [WIDTH-1:0] r);
    logic [WIDTH-1:0] m;
    m = r - WIDTH'(1);
    for (int i = 0; i < WIDTH; i++) begin
      m = m | (m >> 1);
    end
    return m;
  endfunction

  // Next-state logic for the draw FSM and the LFSR state, with seed load over advance.
  always_comb begin
    fsm_d      = fsm_q;
    range_d    = range_q;
    mask_d     = mask_q;
    tries_d    = tries_q;
    rsp_d      = rsp_q;
    fallback_d = fallback_q;
    do_advance = bus.next_i;
    lfsr_d     = lfsr_q;
    cand       = lfsr_q & mask_q;
    adv_state  = advance(lfsr_q);
    if (adv_state == '0) begin
      adv_state = SEED;
    end

    unique case (fsm_q)
      IDLE: begin
        if (bus.req_valid_i) begin
          range_d = bus.range_i;
          mask_d  = range_mask(bus.range_i);
          tries_d = '0;
          fsm_d   = DRAW;
        end
      end
      DRAW: begin
        do_advance = 1'b1;
        if ((range_q == '0) || (cand < range_q)) begin
          rsp_d      = cand;
          fallback_d = 1'b0;
          fsm_d      = RESP;
        end else if (tries_q == LAST_TRY) begin
          rsp_d      = cand - range_q;
          fallback_d = 1'b1;
          fsm_d      = RESP;
        end else begin
          tries_d = tries_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready_i) begin
          fsm_d = IDLE;
        end
      end
      default: begin
        fsm_d = IDLE;
      end
    endcase

    if (bus.seed_valid_i) begin
      lfsr_d = (bus.seed_i == '0) ? SEED : bus.seed_i;
    end else if (do_advance) begin
      lfsr_d = adv_state;
    end
  end

  // State registers; reset drops any pending draw and restores the seed.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q      <= IDLE;
      lfsr_q     <= SEED;
      range_q    <= '0;
      mask_q     <= '0;
      tries_q    <= '0;
      rsp_q      <= '0;
      fallback_q <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      lfsr_q     <= lfsr_d;
      range_q    <= range_d;
      mask_q     <= mask_d;
      tries_q    <= tries_d;
      rsp_q      <= rsp_d;
      fallback_q <= fallback_d;
    end
  end

  assign bus.rand_o         = lfsr_q;
  assign bus.req_ready_o    = (fsm_q == IDLE) && !rst_i;
  assign bus.rsp_valid_o    = (fsm_q == RESP);
  assign bus.rsp_o          = rsp_q;
  assign bus.rsp_fallback_o = fallback_q;

endmodule

// File: tb/tb_lfsr_rng.sv
// Self-checking bench for lfsr_rng: default 16-bit instance, a 4-bit
// instance for the period check, and a MAX_TRIES=1 instance for fallback.
module tb_lfsr_rng;

  logic clk;
  logic rst;
  int   passed;
  int   total;

  int unsigned ms_a;
  int unsigned ms_b;
  int unsigned ms_c;

  lfsr_rng_if #(.WIDTH(16)) a_if ();
  lfsr_rng_if #(.WIDTH(4))  b_if ();
  lfsr_rng_if #(.WIDTH(16)) c_if ();

  lfsr_rng #(.WIDTH(16)) dut_a (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (a_if.slave)
  );

  lfsr_rng #(.WIDTH(4), .TAPS(4'hC), .SEED(4'h1)) dut_b (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (b_if.slave)
  );

  lfsr_rng #(.WIDTH(16), .MAX_TRIES(1)) dut_c (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (c_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: polynomial step as parity of tapped bits, zero replaced by seed.
  function automatic int unsigned m_next(int unsigned s, int w, int unsigned taps, int unsigned seed);
    int unsigned full;
    int unsigned fbit;
    int unsigned r;
    full = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    fbit = 32'($countones(s & taps) % 2);
    r    = ((s << 1) | fbit) & full;
    if (r == 0) r = seed;
    return r;
  endfunction

  // Reference: 2^ceil(log2(range)) - 1, all ones for range 0.
  function automatic int unsigned m_mask(int unsigned range, int w);
    int k;
    if (range == 0) return (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    k = 0;
    while ((64'd1 << k) < 64'(range)) k++;
    return 32'((64'd1 << k) - 64'd1);
  endfunction

  // Reference draw: attempts consume one state step each; last reject folds back.
  function automatic void m_draw(inout int unsigned s, input int unsigned range, input int w,
                                 input int unsigned taps, input int unsigned seed, input int max_tries,
                                 output int unsigned val, output bit fb, output int cycles);
    int unsigned mask;
    int unsigned cand;
    val    = 0;
    fb     = 1'b0;
    cycles = 0;
    mask   = m_mask(range, w);
    for (int t = 0; t < max_tries; t++) begin
      cand = s & mask;
      s    = m_next(s, w, taps, seed);
      if (range == 0 || cand < range) begin
        val = cand; fb = 1'b0; cycles = t + 1;
        return;
      end
      if (t == max_tries - 1) begin
        val = cand - range; fb = 1'b1; cycles = t + 1;
        return;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus_idle();
    a_if.next_i = 0; a_if.seed_valid_i = 0; a_if.seed_i = '0;
    a_if.req_valid_i = 0; a_if.range_i = '0; a_if.rsp_ready_i = 0;
    b_if.next_i = 0; b_if.seed_valid_i = 0; b_if.seed_i = '0;
    b_if.req_valid_i = 0; b_if.range_i = '0; b_if.rsp_ready_i = 0;
    c_if.next_i = 0; c_if.seed_valid_i = 0; c_if.seed_i = '0;
    c_if.req_valid_i = 0; c_if.range_i = '0; c_if.rsp_ready_i = 0;
  endtask

  task automatic test_reset();
    applyStimulus_idle();
    rst = 1;
    tick(); tick();
    total++; if (a_if.rand_o !== 16'h0001) $display("[TB] FAIL reset_rand: got %h expected 0001", a_if.rand_o); else passed++;
    total++; if (a_if.rsp_valid_o !== 1'b0) $display("[TB] FAIL reset_rsp_valid: got %b expected 0", a_if.rsp_valid_o); else passed++;
    total++; if (a_if.rsp_o !== 16'h0000 || a_if.rsp_fallback_o !== 1'b0)
      $display("[TB] FAIL reset_rsp: got %h/%b expected 0000/0", a_if.rsp_o, a_if.rsp_fallback_o); else passed++;
    total++; if (a_if.req_ready_o !== 1'b0) $display("[TB] FAIL reset_ready_in_reset: got %b expected 0", a_if.req_ready_o); else passed++;
    total++; if (b_if.rand_o !== 4'h1 || c_if.rand_o !== 16'h0001)
      $display("[TB] FAIL reset_rand_others: got %h/%h expected 1/0001", b_if.rand_o, c_if.rand_o); else passed++;
    rst = 0;
    #1;
    total++; if (a_if.req_ready_o !== 1'b1) $display("[TB] FAIL reset_ready_after: got %b expected 1", a_if.req_ready_o); else passed++;
    ms_a = 1; ms_b = 1; ms_c = 1;
  endtask

  task automatic test_advance_defaults();
    a_if.next_i = 1;
    for (int i = 0; i < 11; i++) begin
      tick();
      ms_a = m_next(ms_a, 16, 32'hB400, 1);
      total++; if (a_if.rand_o !== 16'(ms_a)) $display("[TB] FAIL advance_%0d: got %h expected %h", i, a_if.rand_o, 16'(ms_a)); else passed++;
    end
    a_if.next_i = 0;
    total++; if (a_if.rand_o !== 16'h0801) $display("[TB] FAIL advance_final: got %h expected 0801", a_if.rand_o); else passed++;
  endtask

  task automatic test_seed();
    a_if.seed_valid_i = 1; a_if.seed_i = 16'h0000;
    tick();
    total++; if (a_if.rand_o !== 16'h0001) $display("[TB] FAIL seed_zero: got %h expected 0001", a_if.rand_o); else passed++;
    a_if.seed_i = 16'hACE1; a_if.next_i = 1;
    tick();
    total++; if (a_if.rand_o !== 16'hACE1) $display("[TB] FAIL seed_over_next: got %h expected ACE1", a_if.rand_o); else passed++;
    a_if.seed_i = 16'h0000;
    tick();
    total++; if (a_if.rand_o !== 16'h0001) $display("[TB] FAIL seed_zero_again: got %h expected 0001", a_if.rand_o); else passed++;
    a_if.seed_valid_i = 0; a_if.next_i = 0;
    ms_a = 1;
  endtask

  task automatic test_random_advance();
    bit          nx;
    bit          sv;
    int unsigned sd;
    for (int i = 0; i < 200; i++) begin
      nx = 1'($urandom_range(0, 1));
      sv = ($urandom_range(0, 9) == 0);
      sd = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 65535);
      a_if.next_i = nx; a_if.seed_valid_i = sv; a_if.seed_i = 16'(sd);
      tick();
      if (sv) ms_a = (sd == 0) ? 1 : sd;
      else if (nx) ms_a = m_next(ms_a, 16, 32'hB400, 1);
      total++; if (a_if.rand_o !== 16'(ms_a)) $display("[TB] FAIL random_adv_%0d: got %h expected %h", i, a_if.rand_o, 16'(ms_a)); else passed++;
    end
    a_if.next_i = 0; a_if.seed_valid_i = 0;
  endtask

  task automatic test_period_w4();
    bit        seen [16];
    int        nseen;
    logic [3:0] v;
    for (int i = 0; i < 16; i++) seen[i] = 1'b0;
    nseen = 0;
    b_if.next_i = 1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      v = b_if.rand_o;
      ms_b = m_next(ms_b, 4, 32'hC, 1);
      total++;
      if (v !== 4'(ms_b) || v == 4'h0 || (i < 15 && seen[v]))
        $display("[TB] FAIL period_step_%0d: got %h expected %h (unvisited, non-zero)", i, v, 4'(ms_b));
      else passed++;
      if (!seen[v]) nseen++;
      seen[v] = 1'b1;
    end
    b_if.next_i = 0;
    total++; if (b_if.rand_o !== 4'h1 || nseen != 15)
      $display("[TB] FAIL period_close: got %h with %0d states expected 1 with 15", b_if.rand_o, nseen); else passed++;
  endtask

  task automatic test_range_one();
    a_if.req_valid_i = 1; a_if.range_i = 16'd1; a_if.rsp_ready_i = 0;
    total++; if (a_if.req_ready_o !== 1'b1) $display("[TB] FAIL r1_ready: got %b expected 1", a_if.req_ready_o); else passed++;
    tick();
    a_if.req_valid_i = 0; a_if.range_i = 16'h7777;
    total++; if (a_if.rsp_valid_o !== 1'b0) $display("[TB] FAIL r1_valid_early: got %b expected 0", a_if.rsp_valid_o); else passed++;
    tick();
    ms_a = m_next(ms_a, 16, 32'hB400, 1);
    total++; if (a_if.rsp_valid_o !== 1'b1 || a_if.rsp_o !== 16'h0 || a_if.rsp_fallback_o !== 1'b0)
      $display("[TB] FAIL r1_result: got %b/%h/%b expected 1/0000/0", a_if.rsp_valid_o, a_if.rsp_o, a_if.rsp_fallback_o); else passed++;
    for (int i = 0; i < 3; i++) begin
      a_if.range_i = 16'($urandom);
      tick();
      total++; if (a_if.rsp_valid_o !== 1'b1 || a_if.rsp_o !== 16'h0)
        $display("[TB] FAIL r1_hold_%0d: got %b/%h expected 1/0000", i, a_if.rsp_valid_o, a_if.rsp_o); else passed++;
    end
    a_if.rsp_ready_i = 1;
    tick();
    a_if.rsp_ready_i = 0;
    total++; if (a_if.rsp_valid_o !== 1'b0) $display("[TB] FAIL r1_release: got %b expected 0", a_if.rsp_valid_o); else passed++;
    total++; if (a_if.rand_o !== 16'(ms_a)) $display("[TB] FAIL r1_state: got %h expected %h", a_if.rand_o, 16'(ms_a)); else passed++;
  endtask

  task automatic test_bounded_draws();
    int unsigned rng;
    int unsigned ev;
    bit          efb;
    int          cyc;
    int          lat;
    int          guard;
    bit          done;
    bit          stable;
    bit          rdy;
    a_if.seed_valid_i = 1; a_if.seed_i = 16'hBEEF;
    tick();
    a_if.seed_valid_i = 0;
    ms_a = 32'hBEEF;
    for (int n = 0; n < 1040; n++) begin
      if (n < 1000) rng = 10;
      else begin
        case ((n - 1000) % 8)
          0: rng = 0;
          1: rng = 1;
          2: rng = 2;
          3: rng = 3;
          4: rng = 1000;
          5: rng = 32'h8001;
          6: rng = 32'hFFFF;
          default: rng = $urandom_range(0, 65535);
        endcase
      end
      m_draw(ms_a, rng, 16, 32'hB400, 1, 8, ev, efb, cyc);
      total++; if (a_if.req_ready_o !== 1'b1) $display("[TB] FAIL draw%0d_ready: got %b expected 1", n, a_if.req_ready_o); else passed++;
      a_if.req_valid_i = 1; a_if.range_i = 16'(rng);
      tick();
      a_if.req_valid_i = 0; a_if.range_i = 16'($urandom);
      lat = 1;
      while (a_if.rsp_valid_o !== 1'b1 && lat < 14) begin
        tick();
        lat++;
      end
      total++; if (lat != 1 + cyc) $display("[TB] FAIL draw%0d_latency: got %0d expected %0d", n, lat, 1 + cyc); else passed++;
      total++; if (a_if.rsp_o !== 16'(ev) || a_if.rsp_fallback_o !== efb)
        $display("[TB] FAIL draw%0d_value: got %h/%b expected %h/%b (range %0d)", n, a_if.rsp_o, a_if.rsp_fallback_o, 16'(ev), efb, rng); else passed++;
      total++; if (rng != 0 && !(32'(a_if.rsp_o) < rng))
        $display("[TB] FAIL draw%0d_bound: got %h expected below %0d", n, a_if.rsp_o, rng); else passed++;
      done = 0; stable = 1; guard = 0;
      while (!done) begin
        rdy = (guard >= 10) ? 1'b1 : 1'($urandom_range(0, 1));
        a_if.rsp_ready_i = rdy;
        tick();
        guard++;
        if (rdy) done = 1;
        else if (a_if.rsp_valid_o !== 1'b1 || a_if.rsp_o !== 16'(ev) || a_if.rsp_fallback_o !== efb) stable = 0;
      end
      a_if.rsp_ready_i = 0;
      total++; if (!stable) $display("[TB] FAIL draw%0d_hold: got unstable response expected %h held", n, 16'(ev)); else passed++;
      total++; if (a_if.rsp_valid_o !== 1'b0 || a_if.rand_o !== 16'(ms_a))
        $display("[TB] FAIL draw%0d_after: got %b/%h expected 0/%h", n, a_if.rsp_valid_o, a_if.rand_o, 16'(ms_a)); else passed++;
    end
  endtask

  task automatic test_next_during_draw();
    int unsigned ev;
    a_if.next_i = 1; a_if.req_valid_i = 1; a_if.range_i = 16'd0;
    tick();
    ms_a = m_next(ms_a, 16, 32'hB400, 1);
    a_if.req_valid_i = 0;
    ev = ms_a;
    tick();
    ms_a = m_next(ms_a, 16, 32'hB400, 1);
    total++; if (a_if.rand_o !== 16'(ms_a)) $display("[TB] FAIL nd_single_adv: got %h expected %h", a_if.rand_o, 16'(ms_a)); else passed++;
    total++; if (a_if.rsp_valid_o !== 1'b1 || a_if.rsp_o !== 16'(ev))
      $display("[TB] FAIL nd_result: got %b/%h expected 1/%h", a_if.rsp_valid_o, a_if.rsp_o, 16'(ev)); else passed++;
    a_if.rsp_ready_i = 1;
    tick();
    ms_a = m_next(ms_a, 16, 32'hB400, 1);
    a_if.rsp_ready_i = 0; a_if.next_i = 0;
    total++; if (a_if.rand_o !== 16'(ms_a) || a_if.rsp_valid_o !== 1'b0)
      $display("[TB] FAIL nd_resp_adv: got %h/%b expected %h/0", a_if.rand_o, a_if.rsp_valid_o, 16'(ms_a)); else passed++;
    a_if.req_valid_i = 1; a_if.range_i = 16'd0;
    tick();
    a_if.req_valid_i = 0;
    ev = ms_a;
    a_if.seed_valid_i = 1; a_if.seed_i = 16'h1234;
    tick();
    a_if.seed_valid_i = 0;
    ms_a = 32'h1234;
    total++; if (a_if.rand_o !== 16'h1234 || a_if.rsp_o !== 16'(ev))
      $display("[TB] FAIL sd_draw: got %h/%h expected 1234/%h", a_if.rand_o, a_if.rsp_o, 16'(ev)); else passed++;
    a_if.rsp_ready_i = 1;
    tick();
    a_if.rsp_ready_i = 0;
  endtask

  task automatic test_fallback_mt1();
    int unsigned ev;
    bit          efb;
    int          cyc;
    c_if.seed_valid_i = 1; c_if.seed_i = 16'h000D;
    tick();
    c_if.seed_valid_i = 0;
    ms_c = 32'h000D;
    total++; if (c_if.rand_o !== 16'h000D) $display("[TB] FAIL fb_seed: got %h expected 000D", c_if.rand_o); else passed++;
    m_draw(ms_c, 10, 16, 32'hB400, 1, 1, ev, efb, cyc);
    c_if.req_valid_i = 1; c_if.range_i = 16'd10;
    tick();
    c_if.req_valid_i = 0;
    tick();
    total++; if (c_if.rsp_valid_o !== 1'b1 || c_if.rsp_o !== 16'h0003 || c_if.rsp_fallback_o !== 1'b1)
      $display("[TB] FAIL fb_result: got %b/%h/%b expected 1/0003/1", c_if.rsp_valid_o, c_if.rsp_o, c_if.rsp_fallback_o); else passed++;
    total++; if (c_if.rsp_o !== 16'(ev) || c_if.rand_o !== 16'(ms_c))
      $display("[TB] FAIL fb_model: got %h/%h expected %h/%h", c_if.rsp_o, c_if.rand_o, 16'(ev), 16'(ms_c)); else passed++;
    c_if.rsp_ready_i = 1;
    tick();
    c_if.rsp_ready_i = 0;
    total++; if (c_if.rsp_valid_o !== 1'b0) $display("[TB] FAIL fb_release: got %b expected 0", c_if.rsp_valid_o); else passed++;
  endtask

  task automatic test_reset_mid_draw();
    a_if.seed_valid_i = 1; a_if.seed_i = 16'h5A5A;
    tick();
    a_if.seed_valid_i = 0;
    a_if.req_valid_i = 1; a_if.range_i = 16'd10;
    tick();
    a_if.req_valid_i = 0;
    total++; if (a_if.rsp_valid_o !== 1'b0 || a_if.req_ready_o !== 1'b0)
      $display("[TB] FAIL rd_in_draw: got %b/%b expected 0/0", a_if.rsp_valid_o, a_if.req_ready_o); else passed++;
    rst = 1;
    tick();
    total++; if (a_if.rsp_valid_o !== 1'b0 || a_if.rand_o !== 16'h0001 || a_if.req_ready_o !== 1'b0)
      $display("[TB] FAIL rd_reset: got %b/%h/%b expected 0/0001/0", a_if.rsp_valid_o, a_if.rand_o, a_if.req_ready_o); else passed++;
    a_if.req_valid_i = 1; a_if.range_i = 16'd1;
    tick();
    a_if.req_valid_i = 0;
    rst = 0;
    #1;
    total++; if (a_if.req_ready_o !== 1'b1) $display("[TB] FAIL rd_ready_after: got %b expected 1", a_if.req_ready_o); else passed++;
    a_if.req_valid_i = 1; a_if.range_i = 16'd1;
    tick();
    a_if.req_valid_i = 0;
    tick();
    total++; if (a_if.rsp_valid_o !== 1'b1) $display("[TB] FAIL rr_in_resp: got %b expected 1", a_if.rsp_valid_o); else passed++;
    rst = 1;
    tick();
    rst = 0;
    #1;
    total++; if (a_if.rsp_valid_o !== 1'b0 || a_if.rand_o !== 16'h0001 || a_if.req_ready_o !== 1'b1)
      $display("[TB] FAIL rr_reset: got %b/%h/%b expected 0/0001/1", a_if.rsp_valid_o, a_if.rand_o, a_if.req_ready_o); else passed++;
    ms_a = 1;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    rst    = 1;
    applyStimulus_idle();
    test_reset();
    test_advance_defaults();
    test_seed();
    test_random_advance();
    test_period_w4();
    test_range_one();
    test_bounded_draws();
    test_next_during_draw();
    test_fallback_mt1();
    test_reset_mid_draw();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
